// File: rtl/reg_dump_engine.sv
// Register-file dump engine: reads every register in turn and streams it out on a valid/ready port.
// Optional macro REG_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module reg_dump_engine #(
  parameter int ADDRESS_LEN = 5,
  parameter int N           = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic [ADDRESS_LEN-1:0] rf_rd_addr,
  input  logic [N-1:0]           rf_rd_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N-1:0]           m_data,
  output logic [ADDRESS_LEN-1:0] m_addr,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done
);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, DONE} state_t;
`endif

  localparam logic [ADDRESS_LEN-1:0] MAX_IDX = {ADDRESS_LEN{1'b1}};

  state_t                 state_r;
  state_t                 state_next_s;
  logic [ADDRESS_LEN-1:0] index_r;
  logic [N-1:0]           data_r;
  logic [ADDRESS_LEN-1:0] addr_r;
  logic                   last_r;
  logic                   xfer_s;
`ifdef REG_DUMP_CHECKSUM_EN
  logic [N-1:0]           csum_r;
`endif

  // Abort outranks the sink's ready, so an aborted word never counts as transferred.
  assign xfer_s     = m_ready & ~abort;
  assign rf_rd_addr = (state_r == IDLE) ? {ADDRESS_LEN{1'b0}} : index_r;
  assign m_valid    = (state_r == SEND)
`ifdef REG_DUMP_CHECKSUM_EN
                    | (state_r == CSUM)
`endif
                    ;
  assign busy       = (state_r != IDLE);
  assign done       = (state_r == DONE);
  assign m_data     = data_r;
  assign m_addr     = addr_r;
  assign m_last     = last_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) state_next_s = READ;
        else                 state_next_s = IDLE;
      end
      READ: begin
        if (abort) state_next_s = IDLE;
        else       state_next_s = SEND;
      end
      SEND: begin
        if (abort) begin
          state_next_s = IDLE;
        end else if (xfer_s) begin
          if (index_r != MAX_IDX) begin
            state_next_s = READ;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            state_next_s = CSUM;
`else
            state_next_s = DONE;
`endif
          end
        end else begin
          state_next_s = SEND;
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (abort)       state_next_s = IDLE;
        else if (xfer_s) state_next_s = DONE;
        else             state_next_s = CSUM;
      end
`endif
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Index, output word and checksum datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index_r <= {ADDRESS_LEN{1'b0}};
      data_r  <= {N{1'b0}};
      addr_r  <= {ADDRESS_LEN{1'b0}};
      last_r  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_r  <= {N{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            index_r <= {ADDRESS_LEN{1'b0}};
`ifdef REG_DUMP_CHECKSUM_EN
            csum_r  <= {N{1'b0}};
`endif
          end
        end
        READ: begin
          data_r <= rf_rd_data;
          addr_r <= index_r;
`ifdef REG_DUMP_CHECKSUM_EN
          last_r <= 1'b0;
`else
          last_r <= (index_r == MAX_IDX);
`endif
        end
        SEND: begin
          if (xfer_s) begin
            if (index_r != MAX_IDX) begin
              index_r <= index_r + ADDRESS_LEN'(1);
            end
`ifdef REG_DUMP_CHECKSUM_EN
            csum_r <= csum_r ^ data_r;
            // Final register just left: present the checksum including that word.
            if (index_r == MAX_IDX) begin
              data_r <= csum_r ^ data_r;
              addr_r <= {ADDRESS_LEN{1'b0}};
              last_r <= 1'b1;
            end
`endif
          end
        end
        default: begin
          index_r <= index_r;
        end
      endcase
    end
  end

endmodule
